// File: rtl/servo_scheduler.sv
// Two-requester servo scheduler: round-robin grant, frame-aligned PWM for HOLD_FRAMES frames, one-cycle ack.
// Grant at the IDLE edge; the first pulse begins at the next frame start; ack follows the last frame by one cycle.
module servo_scheduler #(
   parameter int PERIOD_CYC  = 2000000,
   parameter int PULSE_MIN   = 100000,
   parameter int PULSE_MID   = 150000,
   parameter int PULSE_MAX   = 200000,
   parameter int HOLD_FRAMES = 25
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic [1:0] angle0,
   input  logic [1:0] angle1,
   output logic       pwm,
   output logic       busy,
   output logic [1:0] ack,
   output logic       grant_id,
   output logic [1:0] servo_angle
);

   localparam int CW = $clog2(PERIOD_CYC + 1);
   localparam int FW = $clog2(HOLD_FRAMES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(PERIOD_CYC - 1);
   localparam logic [FW-1:0] FRM_LAST = FW'(HOLD_FRAMES - 1);

   typedef enum logic [1:0] {IDLE, ARM, DRIVE, DONE} state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] cnt;
   logic [CW-1:0] width, width_sel;
   logic [FW-1:0] frames, frames_nxt;
   logic          grant_nxt;
   logic          grant_en;
   logic [1:0]    angle_sel;
   logic          frame_end;

   assign frame_end = (cnt == CNT_LAST);

   // Frame timebase runs regardless of state so every move aligns to the same grid.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (frame_end) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

   always_comb begin
      grant_nxt = grant_id;
      case (req)
         2'b01:   grant_nxt = 1'b0;
         2'b10:   grant_nxt = 1'b1;
         2'b11:   grant_nxt = ~grant_id;
         default: grant_nxt = grant_id;
      endcase
      angle_sel = grant_nxt ? angle1 : angle0;
      case (angle_sel)
         2'b00:   width_sel = CW'(PULSE_MIN);
         2'b10:   width_sel = CW'(PULSE_MAX);
         default: width_sel = CW'(PULSE_MID);
      endcase
   end

   always_comb begin
      state_nxt  = state;
      frames_nxt = frames;
      grant_en   = 1'b0;
      case (state)
         IDLE: begin
            if (|req) begin
               grant_en  = 1'b1;
               state_nxt = ARM;
            end
         end
         ARM: begin
            if (frame_end) begin
               state_nxt  = DRIVE;
               frames_nxt = '0;
            end
         end
         DRIVE: begin
            if (frame_end) begin
               if (frames == FRM_LAST) begin
                  state_nxt = DONE;
               end else begin
                  frames_nxt = frames + FW'(1);
               end
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Grant/angle/width are captured only at the grant edge; later input changes are ignored.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         frames      <= '0;
         grant_id    <= 1'b1;
         servo_angle <= 2'b01;
         width       <= CW'(PULSE_MID);
      end else begin
         state  <= state_nxt;
         frames <= frames_nxt;
         if (grant_en) begin
            grant_id    <= grant_nxt;
            servo_angle <= angle_sel;
            width       <= width_sel;
         end
      end
   end

   // Outputs decode registered state directly, so reset clears them without waiting for a clock.
   assign busy = (state != IDLE);
   assign pwm  = (state == DRIVE) && (cnt < width);
   assign ack  = (state == DONE) ? (grant_id ? 2'b10 : 2'b01) : 2'b00;

endmodule

// File: tb/tb_servo_scheduler.sv
// Bench for servo_scheduler: move-level schedule model checked every cycle, plus directed literal checks.
module tb_servo_scheduler;

   localparam int P    = 20;
   localparam int PMIN = 2;
   localparam int PMID = 3;
   localparam int PMAX = 4;
   localparam int H    = 2;

   logic       clk    = 1'b0;
   logic       reset  = 1'b0;
   logic [1:0] req    = 2'b00;
   logic [1:0] angle0 = 2'b00;
   logic [1:0] angle1 = 2'b00;
   logic       pwm;
   logic       busy;
   logic [1:0] ack;
   logic       grant_id;
   logic [1:0] servo_angle;

   int n_chk = 0;
   int n_err = 0;

   // Move schedule model: absolute cycle numbers since reset release.
   int         cyc      = 0;
   bit         m_active = 1'b0;
   int         m_grant  = 0;
   int         m_ds     = 0;
   int         m_done   = 0;
   int         m_width  = PMID;
   logic       m_gid    = 1'b1;
   logic [1:0] m_angle  = 2'b01;

   servo_scheduler #(
      .PERIOD_CYC (P),
      .PULSE_MIN  (PMIN),
      .PULSE_MID  (PMID),
      .PULSE_MAX  (PMAX),
      .HOLD_FRAMES(H)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .req        (req),
      .angle0     (angle0),
      .angle1     (angle1),
      .pwm        (pwm),
      .busy       (busy),
      .ack        (ack),
      .grant_id   (grant_id),
      .servo_angle(servo_angle)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
      end
   endtask

   function automatic int width_of(input logic [1:0] a);
      case (a)
         2'b00:   return PMIN;
         2'b10:   return PMAX;
         default: return PMID;
      endcase
   endfunction

   // A grant in cycle g at phase g%P drives frames starting at the next phase-0 cycle.
   always @(posedge clk) begin
      if (!reset) begin
         cyc      = 0;
         m_active = 1'b0;
         m_gid    = 1'b1;
         m_angle  = 2'b01;
      end else begin
         if ((!m_active || cyc > m_done) && req != 2'b00) begin
            if (req == 2'b01)      m_gid = 1'b0;
            else if (req == 2'b10) m_gid = 1'b1;
            else                   m_gid = ~m_gid;
            m_angle  = m_gid ? angle1 : angle0;
            m_width  = width_of(m_angle);
            m_grant  = cyc;
            m_ds     = cyc + (P - cyc % P);
            m_done   = m_ds + H * P;
            m_active = 1'b1;
         end
         cyc++;
      end
   end

   always @(negedge clk) begin : cmp
      bit in_move;
      int e_busy, e_pwm, e_ack;
      in_move = reset && m_active;
      e_busy  = (in_move && cyc > m_grant && cyc <= m_done) ? 1 : 0;
      e_pwm   = (in_move && cyc >= m_ds && cyc < m_done && ((cyc - m_ds) % P) < m_width) ? 1 : 0;
      e_ack   = (in_move && cyc == m_done) ? (m_gid ? 2 : 1) : 0;
      chk("busy", int'(busy), e_busy);
      chk("pwm", int'(pwm), e_pwm);
      chk("ack", int'(ack), e_ack);
      chk("grant_id", int'(grant_id), int'(m_gid));
      chk("servo_angle", int'(servo_angle), int'(m_angle));
   end

   // Observe one move until busy falls after its ack; clr masks req bits dropped on ack.
   task automatic watch(input logic [1:0] clr, input bit mut,
                        output int bc, output int pc, output int ac, output int av, output int rise);
      bit prev    = 1'b0;
      bit mutated = 1'b0;
      bit fin     = 1'b0;
      bc = 0; pc = 0; ac = 0; av = 0; rise = -1;
      for (int i = 0; i < 400 && !fin; i++) begin
         @(negedge clk);
         if (busy) bc++;
         if (pwm) begin
            pc++;
            if (!prev && rise < 0) rise = cyc % P;
            if (mut && !mutated) begin
               req     = 2'b00;
               angle0  = 2'b00;
               mutated = 1'b1;
            end
         end
         prev = pwm;
         if (ack != 2'b00) begin
            ac++;
            av  = int'(ack);
            req = req & ~clr;
         end else if (ac > 0 && !busy) begin
            fin = 1'b1;
         end
      end
      if (!fin) chk("watch_timeout", 1, 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #1 reset = 1'b0;
      req = 2'b00;
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   initial begin
      int bc, pc, ac, av, rise;

      repeat (3) @(negedge clk);
      chk("rst_busy", int'(busy), 0);
      chk("rst_pwm", int'(pwm), 0);
      chk("rst_ack", int'(ack), 0);
      chk("rst_grant_id", int'(grant_id), 1);
      chk("rst_servo_angle", int'(servo_angle), 1);

      // Single move, RIGHT, requested in cycle 0
      reset = 1'b1; req = 2'b01; angle0 = 2'b10;
      watch(2'b01, 1'b0, bc, pc, ac, av, rise);
      chk("single_busy_cycles", bc, 60);
      chk("single_pwm_high", pc, 8);
      chk("single_ack_count", ac, 1);
      chk("single_ack", av, 1);
      chk("single_rise_phase", rise, 0);

      // Tie held: req0, req1, req0
      do_reset();
      req = 2'b11; angle0 = 2'b00; angle1 = 2'b01;
      watch(2'b00, 1'b0, bc, pc, ac, av, rise);
      chk("tie1_busy_cycles", bc, 60);
      chk("tie1_pwm_high", pc, 4);
      chk("tie1_ack", av, 1);
      watch(2'b00, 1'b0, bc, pc, ac, av, rise);
      chk("tie2_busy_cycles", bc, 59);
      chk("tie2_pwm_high", pc, 6);
      chk("tie2_ack", av, 2);
      watch(2'b11, 1'b0, bc, pc, ac, av, rise);
      chk("tie3_busy_cycles", bc, 59);
      chk("tie3_pwm_high", pc, 4);
      chk("tie3_ack", av, 1);

      // Request arriving at counter phase 7
      for (int i = 0; i < 40 && (cyc % P) != 7; i++) @(negedge clk);
      chk("align_phase", cyc % P, 7);
      req = 2'b01; angle0 = 2'b00;
      watch(2'b01, 1'b0, bc, pc, ac, av, rise);
      chk("align_busy_cycles", bc, 53);
      chk("align_pwm_high", pc, 4);
      chk("align_rise_phase", rise, 0);
      chk("align_ack", av, 1);

      // req and angle changed mid-DRIVE are ignored
      req = 2'b01; angle0 = 2'b10;
      watch(2'b01, 1'b1, bc, pc, ac, av, rise);
      chk("drop_pwm_high", pc, 8);
      chk("drop_ack_count", ac, 1);
      chk("drop_ack", av, 1);

      // Reset during a pwm-high cycle
      req = 2'b01; angle0 = 2'b10;
      for (int i = 0; i < 100 && !pwm; i++) @(negedge clk);
      chk("rstmid_pwm_seen", int'(pwm), 1);
      #1 reset = 1'b0;
      #1;
      chk("rstmid_pwm", int'(pwm), 0);
      chk("rstmid_busy", int'(busy), 0);
      chk("rstmid_ack", int'(ack), 0);
      repeat (3) @(negedge clk);
      req = 2'b10; angle1 = 2'b01; reset = 1'b1;
      watch(2'b10, 1'b0, bc, pc, ac, av, rise);
      chk("rstmid_busy_cycles", bc, 60);
      chk("rstmid_pwm_high", pc, 6);
      chk("rstmid_ack", av, 2);
      chk("rstmid_grant_id", int'(grant_id), 1);

      // Angle code 11 maps to CENTER
      req = 2'b10; angle1 = 2'b11;
      watch(2'b10, 1'b0, bc, pc, ac, av, rise);
      chk("code11_pwm_high", pc, 6);
      chk("code11_ack", av, 2);
      chk("code11_servo_angle", int'(servo_angle), 3);

      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
